// File: rtl/multicycle_datapath.sv
// Multi-cycle RV32-style datapath with FETCH/DECODE/EXEC/MEM/WB sequencer.
// Instruction and data ports use req/ack handshakes with arbitrary wait states.
module multicycle_datapath #(
    parameter int XLEN = 32,
    parameter int NREGS = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] Data_out,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] Data_in,
    output logic [31:0]     inst_out,
    input  logic [3:0]      ALU_Control,
    input  logic [2:0]      ImmSel,
    input  logic [1:0]      MemtoReg,
    input  logic            ALUSrc_B,
    input  logic [1:0]      Jump,
    input  logic            Branch,
    input  logic            BranchN,
    input  logic            RegWrite,
    input  logic            MemRW,
    input  logic            MemRead,
    output logic [XLEN-1:0] PC_out,
    output logic [XLEN-1:0] ALU_out,
    output logic [2:0]      state_out,
    output logic            retire
);
    localparam int AW = $clog2(NREGS);
    localparam int SW = $clog2(XLEN);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, a_q, b_q, alu_q, mdr_q;
    logic [31:0]     ir_q;
    logic            zero_q;
    logic [XLEN-1:0] rf_q [NREGS];

    logic            ir_we, ab_we, alu_we, mdr_we, pc_we, rf_we;
    logic [AW-1:0]   rs1, rs2, rd;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm, op_b, alu_res, alu_v;
    logic [XLEN-1:0] pc_plus4, pc_imm, next_pc, wb_data;
    logic            zero_c, zero, taken;

    assign rs1 = ir_q[15 +: AW];
    assign rs2 = ir_q[20 +: AW];
    assign rd  = ir_q[7 +: AW];
    assign rs1_data = (rs1 == '0) ? '0 : rf_q[rs1];
    assign rs2_data = (rs2 == '0) ? '0 : rf_q[rs2];

    // ImmSel: 0 I, 1 S, 2 B, 3 J, 4 U
    always_comb begin
        imm32 = '0;
        case (ImmSel)
            3'd0: imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
            3'd1: imm32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            3'd2: imm32 = {{19{ir_q[31]}}, ir_q[31], ir_q[7],
                           ir_q[30:25], ir_q[11:8], 1'b0};
            3'd3: imm32 = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12],
                           ir_q[20], ir_q[30:21], 1'b0};
            3'd4: imm32 = {ir_q[31:12], 12'b0};
            default: imm32 = '0;
        endcase
    end
    assign imm  = XLEN'($signed(imm32));
    assign op_b = ALUSrc_B ? imm : b_q;

    // ALU_Control = {funct7[5], funct3}
    always_comb begin
        alu_res = a_q + op_b;
        case (ALU_Control)
            4'b1000: alu_res = a_q - op_b;
            4'b0001: alu_res = a_q << op_b[SW-1:0];
            4'b0010: alu_res = XLEN'($signed(a_q) < $signed(op_b));
            4'b0011: alu_res = XLEN'(a_q < op_b);
            4'b0100: alu_res = a_q ^ op_b;
            4'b0101: alu_res = a_q >> op_b[SW-1:0];
            4'b1101: alu_res = $signed(a_q) >>> op_b[SW-1:0];
            4'b0110: alu_res = a_q | op_b;
            4'b0111: alu_res = a_q & op_b;
            default: alu_res = a_q + op_b;
        endcase
    end
    assign zero_c = (alu_res == '0);

    // EXEC retires before ALUOut/zero are registered, so it uses the live values
    assign zero  = (state_q == S_EXEC) ? zero_c : zero_q;
    assign alu_v = (state_q == S_EXEC) ? alu_res : alu_q;
    assign taken = (Branch & zero) | (BranchN & ~zero);
    assign pc_plus4 = pc_q + XLEN'(4);
    assign pc_imm   = pc_q + imm;

    always_comb begin
        case (Jump)
            2'd1:    next_pc = pc_imm;
            2'd2:    next_pc = {alu_v[XLEN-1:1], 1'b0};
            default: next_pc = taken ? pc_imm : pc_plus4;
        endcase
    end

    always_comb begin
        case (MemtoReg)
            2'd1:    wb_data = mdr_q;
            2'd2:    wb_data = pc_plus4;
            2'd3:    wb_data = imm;
            default: wb_data = alu_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        retire   = 1'b0;
        ir_we    = 1'b0;
        ab_we    = 1'b0;
        alu_we   = 1'b0;
        mdr_we   = 1'b0;
        pc_we    = 1'b0;
        rf_we    = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_we   = 1'b1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    ab_we   = 1'b1;
                    state_d = S_EXEC;
                end
                S_EXEC: begin
                    alu_we = 1'b1;
                    if (MemRead | MemRW) begin
                        state_d = S_MEM;
                    end else if (RegWrite) begin
                        state_d = S_WB;
                    end else begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = MemRW;
                    if (dmem_ack) begin
                        if (MemRW) begin
                            pc_we   = 1'b1;
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            mdr_we  = 1'b1;
                            state_d = S_WB;
                        end
                    end
                end
                S_WB: begin
                    rf_we   = (rd != '0);
                    pc_we   = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            zero_q  <= 1'b0;
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (ir_we) ir_q <= imem_rdata;
            if (ab_we) begin
                a_q <= rs1_data;
                b_q <= rs2_data;
            end
            if (alu_we) begin
                alu_q  <= alu_res;
                zero_q <= zero_c;
            end
            if (mdr_we) mdr_q <= Data_in;
            if (pc_we) pc_q <= next_pc;
            if (rf_we) rf_q[rd] <= wb_data;
        end
    end

    assign imem_addr = pc_q;
    assign dmem_addr = alu_q;
    assign Data_out  = b_q;
    assign inst_out  = ir_q;
    assign PC_out    = pc_q;
    assign ALU_out   = alu_q;
    assign state_out = state_q;
endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench: decoder, wait-state memories and a retire scoreboard
// checking latency, fetch address and next PC of each instruction.
module tb_multicycle_datapath;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, Data_out, Data_in;
    logic [31:0] inst_out, PC_out, ALU_out;
    logic [3:0]  ALU_Control;
    logic [2:0]  ImmSel, state_out;
    logic [1:0]  MemtoReg, Jump;
    logic        ALUSrc_B, Branch, BranchN, RegWrite, MemRW, MemRead;
    logic        retire;

    multicycle_datapath dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .Data_out(Data_out),
        .dmem_ack(dmem_ack), .Data_in(Data_in),
        .inst_out(inst_out), .ALU_Control(ALU_Control),
        .ImmSel(ImmSel), .MemtoReg(MemtoReg),
        .ALUSrc_B(ALUSrc_B), .Jump(Jump),
        .Branch(Branch), .BranchN(BranchN),
        .RegWrite(RegWrite), .MemRW(MemRW), .MemRead(MemRead),
        .PC_out(PC_out), .ALU_out(ALU_out),
        .state_out(state_out), .retire(retire)
    );

    always #5 clk = ~clk;

    // external decoder for the handful of opcodes used here
    always_comb begin
        ALU_Control = 4'd0;
        ImmSel      = 3'd0;
        MemtoReg    = 2'd0;
        ALUSrc_B    = 1'b0;
        Jump        = 2'd0;
        Branch      = 1'b0;
        BranchN     = 1'b0;
        RegWrite    = 1'b0;
        MemRW       = 1'b0;
        MemRead     = 1'b0;
        case (inst_out[6:0])
            7'h13: begin ALUSrc_B = 1'b1; RegWrite = 1'b1; end
            7'h33: RegWrite = 1'b1;
            7'h23: begin ImmSel = 3'd1; ALUSrc_B = 1'b1; MemRW = 1'b1; end
            7'h03: begin
                ALUSrc_B = 1'b1; MemRead = 1'b1;
                RegWrite = 1'b1; MemtoReg = 2'd1;
            end
            7'h63: begin
                ALU_Control = 4'b1000; ImmSel = 3'd2;
                Branch  = (inst_out[14:12] == 3'd0);
                BranchN = (inst_out[14:12] == 3'd1);
            end
            7'h67: begin
                ALUSrc_B = 1'b1; Jump = 2'd2;
                RegWrite = 1'b1; MemtoReg = 2'd2;
            end
            default: ;
        endcase
    end

    logic [31:0] imem [0:63];
    logic [31:0] dmem [0:15];
    int imem_wait = 0, dmem_wait = 0;
    int icnt = 0, dcnt = 0, dwrites = 0;
    logic imem_force = 1'b0, dmem_force = 1'b0;

    assign imem_rdata = imem[imem_addr[7:2]];
    assign Data_in    = dmem[dmem_addr[5:2]];
    assign imem_ack   = imem_force | (imem_req && icnt >= imem_wait);
    assign dmem_ack   = dmem_force | (dmem_req && dcnt >= dmem_wait);

    always @(posedge clk) begin
        icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
        dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
        if (dmem_req && dmem_ack && dmem_we) begin
            dmem[dmem_addr[5:2]] <= Data_out;
            dwrites <= dwrites + 1;
        end
    end

    // request monitor: cycle counts, last data access, address stability
    int dreq_total = 0, stab_err = 0;
    logic [31:0] last_daddr, last_ddata, p_daddr, p_ddata, p_iaddr;
    logic last_dwe, p_dwe, p_dreq = 1'b0, p_ireq = 1'b0;
    always @(negedge clk) begin
        if (dmem_req) begin
            dreq_total <= dreq_total + 1;
            last_daddr <= dmem_addr;
            last_ddata <= Data_out;
            last_dwe   <= dmem_we;
            if (p_dreq && (dmem_addr !== p_daddr || Data_out !== p_ddata
                           || dmem_we !== p_dwe))
                stab_err <= stab_err + 1;
        end
        if (imem_req && p_ireq && imem_addr !== p_iaddr)
            stab_err <= stab_err + 1;
        p_dreq  <= dmem_req;
        p_daddr <= dmem_addr;
        p_ddata <= Data_out;
        p_dwe   <= dmem_we;
        p_ireq  <= imem_req;
        p_iaddr <= imem_addr;
    end

    int errors = 0, checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc0;
        logic [31:0] pc1;
        int          lat;
    } exp_t;
    exp_t sb[$];
    int trc;

    task automatic expect_instr(input logic [31:0] pc0,
                                input logic [31:0] pc1, input int lat);
        exp_t e;
        e.pc0 = pc0;
        e.pc1 = pc1;
        e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic retire_one();
        exp_t e;
        int cnt;
        bit done;
        logic [31:0] fa;
        e = sb.pop_front();
        cnt = 0;
        done = 1'b0;
        trc = 0;
        fa = '1;
        while (!done && cnt < 60) begin
            @(negedge clk);
            cnt++;
            trc = trc * 8 + int'(state_out);
            if (cnt == 1) fa = imem_addr;
            if (retire) done = 1'b1;
        end
        chk("retire_seen", 32'(done), 32'd1);
        chk("latency", 32'(cnt), 32'(e.lat));
        chk("fetch_addr", fa, e.pc0);
        @(posedge clk);
        #1;
        chk("next_pc", PC_out, e.pc1);
    endtask

    initial begin
        int d0, k;
        for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
        imem[0] = 32'h0050_0093;   // addi x1,x0,5
        imem[1] = 32'h0010_8133;   // add  x2,x1,x1
        imem[2] = 32'h0020_2423;   // sw   x2,8(x0)
        imem[3] = 32'h0080_2203;   // lw   x4,8(x0)
        imem[4] = 32'hFE00_0CE3;   // beq  x0,x0,-8
        imem[5] = 32'h0040_2623;   // sw   x4,12(x0)
        imem[8] = 32'h0000_81E7;   // jalr x3,x1,0

        rst = 1'b1;
        imem_force = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_pc", PC_out, 32'h0);
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_dmem_req", 32'(dmem_req), 32'h0);
        chk("rst_retire", 32'(retire), 32'h0);
        chk("rst_state", 32'(state_out), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        imem_force = 1'b0;

        expect_instr(32'h00, 32'h04, 4);
        retire_one();
        chk("state_trace", 32'(trc), 32'o0124);
        expect_instr(32'h04, 32'h08, 4);
        retire_one();
        chk("no_dmem_req", 32'(dreq_total), 32'h0);

        d0 = dreq_total;
        dmem_wait = 3;
        expect_instr(32'h08, 32'h0C, 7);
        retire_one();
        chk("st_req_cycles", 32'(dreq_total - d0), 32'd4);
        chk("st_addr", last_daddr, 32'd8);
        chk("st_data", last_ddata, 32'd10);
        chk("st_we", 32'(last_dwe), 32'd1);
        chk("st_mem", dmem[2], 32'd10);

        dmem_wait = 0;
        imem_wait = 2;
        expect_instr(32'h0C, 32'h10, 7);
        retire_one();
        chk("ld_we", 32'(last_dwe), 32'd0);

        imem_wait = 0;
        expect_instr(32'h10, 32'h08, 3);
        retire_one();
        imem[4] = 32'h0070_0093;   // addi x1,x0,7
        imem[1] = 32'h0030_2823;   // sw   x3,16(x0)

        expect_instr(32'h08, 32'h0C, 4);
        expect_instr(32'h0C, 32'h10, 5);
        expect_instr(32'h10, 32'h14, 4);
        expect_instr(32'h14, 32'h18, 4);
        for (int i = 0; i < 4; i++) retire_one();
        chk("ld_value_addr", last_daddr, 32'd12);
        chk("ld_value_data", last_ddata, 32'd10);

        expect_instr(32'h18, 32'h1C, 4);
        expect_instr(32'h1C, 32'h20, 4);
        expect_instr(32'h20, 32'h06, 4);
        expect_instr(32'h06, 32'h0A, 4);
        for (int i = 0; i < 4; i++) retire_one();
        chk("jalr_link_addr", last_daddr, 32'd16);
        chk("jalr_link_data", last_ddata, 32'h24);

        dmem_wait = 5;
        k = 0;
        while (state_out !== 3'd3 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("reach_mem", 32'(state_out), 32'd3);
        @(negedge clk);
        chk("mem_wait_req", 32'(dmem_req), 32'd1);
        d0 = dwrites;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_state", 32'(state_out), 32'd0);
        chk("midrst_pc", PC_out, 32'h0);
        chk("midrst_dreq", 32'(dmem_req), 32'd0);
        chk("midrst_ireq", 32'(imem_req), 32'd0);
        rst = 1'b0;
        dmem_wait = 0;
        imem_wait = 3;
        dmem_force = 1'b1;
        @(negedge clk);
        chk("spur_state", 32'(state_out), 32'd0);
        chk("spur_dreq", 32'(dmem_req), 32'd0);
        @(posedge clk);
        #1;
        dmem_force = 1'b0;
        chk("spur_ignored", 32'(state_out), 32'd0);
        chk("midrst_no_write", 32'(dwrites - d0), 32'd0);
        expect_instr(32'h00, 32'h04, 6);
        retire_one();

        chk("req_stable", 32'(stab_err), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
